// File: rtl/ram8x16.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram8x16 : 8-word x 16-bit register RAM, synchronous write, async read    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ram8x16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic [2:0]  address,
  output logic [15:0] out
);

  localparam int c_DEPTH = 8;

  logic [c_DEPTH-1:0] w_load;
  logic [15:0]        w_word [c_DEPTH];

  // One-hot demux of the write enable; all-zero when load is low.
  always_comb begin
    w_load = '0;
    if (load) begin
      w_load = 8'b0000_0001 << address;
    end
  end

  generate
    for (genvar g = 0; g < c_DEPTH; g++) begin : g_word
      logic [15:0] r_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else if (w_load[g]) begin
          r_q <= in;
        end
      end

      assign w_word[g] = r_q;
    end
  endgenerate

  assign out = w_word[address];

endmodule
`default_nettype wire

// File: tb/tb_ram8x16.sv
`default_nettype none
`timescale 1ns/100ps
// +--------------------------------------------------------------------------+
// | tb_ram8x16 : scoreboard bench for ram8x16 with directed vectors          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ram8x16;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic [15:0] out;

  typedef struct {
    string       nm;
    logic [15:0] exp;
  } item_t;

  item_t sb[$];
  event  sample_ev;
  int    checks;
  int    failures;

  ram8x16 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in),
    .load    (load),
    .address (address),
    .out     (out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Monitor: samples out shortly after each request and scores it.
  initial begin
    item_t it;
    forever begin
      @(sample_ev);
      #0.5;
      while (sb.size() > 0) begin
        it = sb.pop_front();
        checks++;
        if (out !== it.exp) begin
          failures++;
          $display("FAIL %s: out=%h expected=%h", it.nm, out, it.exp);
        end
      end
    end
  end

  task automatic expect_out(input string nm, input logic [15:0] e);
    item_t it;
    it.nm  = nm;
    it.exp = e;
    sb.push_back(it);
    -> sample_ev;
    #1;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s: monitor did not sample, expected=%h", nm, e);
      sb.delete();
    end
  endtask

  task automatic check_all(input string nm, input logic [15:0] e [8]);
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      expect_out($sformatf("%s_a%0d", nm, a), e[a]);
    end
  endtask

  logic [15:0] zeros  [8];
  logic [15:0] filled [8];

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    in       = 16'h0;
    load     = 1'b0;
    address  = 3'd0;
    for (int a = 0; a < 8; a++) begin
      zeros[a]  = 16'h0000;
      filled[a] = 16'(a) << 12;
    end

    @(negedge clk);
    rst_n = 1'b1;
    // Dirty one word so the reset pulse has something to clear.
    in = 16'hBEEF; address = 3'd1; load = 1'b1;
    @(posedge clk); #1;
    expect_out("pre_write", 16'hBEEF);

    // Reset pulse between edges: zeros must appear without a clock edge.
    #3;
    load  = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all("reset", zeros);
    rst_n = 1'b1;

    // Sequential fill.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      address = 3'(k);
      in      = 16'(k) << 12;
      load    = 1'b1;
      @(posedge clk); #1;
      expect_out($sformatf("fill_%0d", k), 16'(k) << 12);
    end
    @(negedge clk);
    load = 1'b0;

    check_all("readback", filled);

    // Hold with load low and in driven to all ones.
    @(negedge clk);
    address = 3'd3;
    in      = 16'hFFFF;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      expect_out($sformatf("hold_%0d", n), 16'h3000);
    end
    @(negedge clk);
    check_all("hold_all", filled);

    // Overwrite address 5: old value before the edge, new value after.
    @(negedge clk);
    address = 3'd5;
    in      = 16'hABCD;
    load    = 1'b1;
    expect_out("ovw_before", 16'h5000);
    @(posedge clk); #1;
    expect_out("ovw_after", 16'hABCD);
    @(negedge clk);
    load    = 1'b0;
    address = 3'd4;
    expect_out("iso_a4", 16'h4000);
    address = 3'd6;
    expect_out("iso_a6", 16'h6000);
    address = 3'd5;
    expect_out("iso_a5", 16'hABCD);

    // Reset held across an edge with a write pending.
    @(negedge clk);
    address = 3'd2;
    in      = 16'h1234;
    load    = 1'b1;
    rst_n   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    load  = 1'b0;
    rst_n = 1'b1;
    check_all("rst_mid", zeros);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
